// File: rtl/dmem_responder_if.sv
// Request/response bundle between the datapath (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with wait states, byte-lane stores,
// address/alignment errors and store-tracking status registers.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [15:0]       store_count,
    output logic [31:0]       last_wr_addr,
    output logic [31:0]       last_wr_data
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR =
        {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, nextState;
    logic [3:0]  waitCnt, waitNext;

    logic        latWe;
    logic [31:0] latAddr, latWdata;
    logic [3:0]  latBe;

    logic        curWe;
    logic [31:0] curAddr, curWdata;
    logic [3:0]  curBe;
    logic        err, enterResp, commit;
    logic [IDXW-1:0] idx;
    logic [31:0] oldWord, newWord;

    logic        rspValid, rspErr;
    logic [31:0] rspRdata;
    logic [15:0] storeCnt;
    logic [31:0] lastWrAddr, lastWrData;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        nextState = state;
        waitNext  = waitCnt;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                        waitNext  = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                waitNext = waitCnt - 4'd1;
                if (waitCnt == 4'd1) nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            latBe    <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            latWe    <= bus.req_we;
            latAddr  <= bus.req_addr;
            latWdata <= bus.req_wdata;
            latBe    <= bus.req_be;
        end
    end

    // With zero wait states the commit edge is also the accept edge,
    // so the live request is used instead of the latched copy.
    assign curWe    = (state == IDLE) ? bus.req_we    : latWe;
    assign curAddr  = (state == IDLE) ? bus.req_addr  : latAddr;
    assign curWdata = (state == IDLE) ? bus.req_wdata : latWdata;
    assign curBe    = (state == IDLE) ? bus.req_be    : latBe;

    assign err = (curAddr[1:0] != 2'b00)
               || ({1'b0, curAddr} < {1'b0, BASE_ADDR})
               || ({1'b0, curAddr} >= END_ADDR);
    assign idx       = IDXW'((curAddr - BASE_ADDR) >> 2);
    assign oldWord   = mem[idx];
    assign enterResp = (nextState == RESP);
    assign commit    = enterResp && curWe && !err;

    always_comb begin
        newWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (curBe[i]) newWord[8*i +: 8] = curWdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= newWord;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspValid   <= 1'b0;
            rspRdata   <= '0;
            rspErr     <= 1'b0;
            storeCnt   <= '0;
            lastWrAddr <= '0;
            lastWrData <= '0;
        end else begin
            rspValid <= enterResp;
            rspErr   <= enterResp && err;
            rspRdata <= (enterResp && !curWe && !err) ? oldWord : '0;
            if (commit) begin
                storeCnt   <= storeCnt + 16'd1;
                lastWrAddr <= curAddr;
                lastWrData <= newWord;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_rdata = rspRdata;
    assign bus.rsp_err   = rspErr;
    assign store_count   = storeCnt;
    assign last_wr_addr  = lastWrAddr;
    assign last_wr_data  = lastWrData;

endmodule
